// File: rtl/mmio_address_router_if.sv
// Master-side request/response bus of the MMIO address router.
// The slave modport is the router's view; master is the requester's.
interface mmio_address_router_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_address_i;
    logic        req_write_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_strobe_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_error_o;
    logic        busy_o;

    modport master (
        output req_valid_i, req_address_i, req_write_i,
        output req_data_i, req_strobe_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
        input  rsp_error_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_address_i, req_write_i,
        input  req_data_i, req_strobe_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
        output rsp_error_o, busy_o
    );
endinterface

// File: rtl/mmio_address_router.sv
// SoC address map and a single-outstanding MMIO router that decodes
// master requests onto one of NETWORK_DEVICES slave ports.
package soc_parameters;
    parameter int NETWORK_DEVICES = 9;

    // Slave 6 overlaps the top half of slave 5; slave 5 wins there.
    parameter logic [31:0] LOW_SLAVE_ADDRESS [NETWORK_DEVICES] = '{
        32'h4000_0000, 32'h4000_1000, 32'h4000_2000,
        32'h4000_3000, 32'h4000_4000, 32'h4000_5000,
        32'h4000_5800, 32'h4000_7000, 32'h4000_8000
    };
    parameter logic [31:0] HIGH_SLAVE_ADDRESS [NETWORK_DEVICES] = '{
        32'h4000_0FFF, 32'h4000_1FFF, 32'h4000_2FFF,
        32'h4000_3FFF, 32'h4000_4FFF, 32'h4000_5FFF,
        32'h4000_6FFF, 32'h4000_7FFF, 32'h4000_8FFF
    };
endpackage

module mmio_address_router #(
    parameter int NETWORK_DEVICES = soc_parameters::NETWORK_DEVICES,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    mmio_address_router_if.slave              bus,
    output logic [NETWORK_DEVICES-1:0]        slv_req_valid_o,
    input  logic [NETWORK_DEVICES-1:0]        slv_req_ready_i,
    output logic [31:0]                       slv_address_o,
    output logic                              slv_write_o,
    output logic [31:0]                       slv_data_o,
    output logic [3:0]                        slv_strobe_o,
    input  logic [NETWORK_DEVICES-1:0]        slv_rsp_valid_i,
    input  logic [NETWORK_DEVICES-1:0][31:0]  slv_rsp_data_i,
    input  logic [NETWORK_DEVICES-1:0]        slv_rsp_error_i
);
    localparam int SW = (NETWORK_DEVICES > 1) ? $clog2(NETWORK_DEVICES) : 1;
    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    strobe_q, strobe_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_err_q, rsp_err_d;

    logic          dec_hit;
    logic [SW-1:0] dec_idx;
    logic          timed_out;

    // Scan downward so the lowest matching index is the last to assign.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NETWORK_DEVICES - 1; i >= 0; i--) begin
            if (bus.req_address_i >= soc_parameters::LOW_SLAVE_ADDRESS[i] &&
                bus.req_address_i <= soc_parameters::HIGH_SLAVE_ADDRESS[i]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    // >= rather than == so a handshake on the limit cycle still leaves
    // the following WAIT bounded.
    assign timed_out = (cnt_q >= TLAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        data_d     = data_q;
        strobe_d   = strobe_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    addr_d     = bus.req_address_i;
                    write_d    = bus.req_write_i;
                    data_d     = bus.req_data_i;
                    strobe_d   = bus.req_strobe_i;
                    sel_d      = dec_idx;
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    if (dec_hit && bus.req_address_i[1:0] == 2'b00) begin
                        rsp_err_d = OKAY;
                        state_d   = ISSUE;
                    end else begin
                        rsp_err_d = DECERR;
                        state_d   = RESPOND;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                if (slv_req_ready_i[sel_q]) begin
                    state_d = WAIT;
                end else if (timed_out) begin
                    rsp_err_d = SLVERR;
                    state_d   = RESPOND;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (slv_rsp_valid_i[sel_q]) begin
                    rsp_data_d = slv_rsp_data_i[sel_q];
                    rsp_err_d  = slv_rsp_error_i[sel_q] ? SLVERR : OKAY;
                    state_d    = RESPOND;
                end else if (timed_out) begin
                    rsp_err_d = SLVERR;
                    state_d   = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            data_q     <= '0;
            strobe_q   <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        slv_req_valid_o = '0;
        if (state_q == ISSUE) begin
            slv_req_valid_o[sel_q] = 1'b1;
        end
    end

    // IDLE is the reset state, so ready must also be masked by rst_i.
    assign bus.req_ready_o = (state_q == IDLE) && !rst_i;
    assign bus.rsp_valid_o = (state_q == RESPOND);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_error_o = rsp_err_q;

    assign slv_address_o = addr_q;
    assign slv_write_o   = write_q;
    assign slv_data_o    = data_q;
    assign slv_strobe_o  = strobe_q;
endmodule

// File: tb/tb_mmio_address_router.sv
// Randomized bench for mmio_address_router against a cycle-count
// reference model derived from the address map and timeout rules.
module tb_mmio_address_router;
    import soc_parameters::*;

    localparam int N = soc_parameters::NETWORK_DEVICES;
    localparam int T = 16;
    localparam int LIMIT = T + 6;

    logic clk;
    logic rst;

    logic [N-1:0]       slv_req_valid;
    logic [N-1:0]       slv_req_ready;
    logic [31:0]        slv_address;
    logic               slv_write;
    logic [31:0]        slv_data;
    logic [3:0]         slv_strobe;
    logic [N-1:0]       slv_rsp_valid;
    logic [N-1:0][31:0] slv_rsp_data;
    logic [N-1:0]       slv_rsp_error;

    int n_checks = 0;
    int n_errors = 0;

    mmio_address_router_if bus_if ();

    mmio_address_router #(
        .NETWORK_DEVICES(N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus_if),
        .slv_req_valid_o(slv_req_valid),
        .slv_req_ready_i(slv_req_ready),
        .slv_address_o  (slv_address),
        .slv_write_o    (slv_write),
        .slv_data_o     (slv_data),
        .slv_strobe_o   (slv_strobe),
        .slv_rsp_valid_i(slv_rsp_valid),
        .slv_rsp_data_i (slv_rsp_data),
        .slv_rsp_error_i(slv_rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lowest-numbered range containing an aligned address, else -1.
    function automatic int ref_decode(input logic [31:0] a);
        if (a[1:0] != 2'b00) return -1;
        for (int i = 0; i < N; i++) begin
            if (a >= LOW_SLAVE_ADDRESS[i] && a <= HIGH_SLAVE_ADDRESS[i])
                return i;
        end
        return -1;
    endfunction

    task automatic clear_slaves();
        slv_req_ready = '0;
        slv_rsp_valid = '0;
        slv_rsp_data  = '0;
        slv_rsp_error = '0;
    endtask

    // Caller is 1 time unit after a rising edge. Cycle 0 is acceptance.
    task automatic run_txn(input string tag,
                           input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           input int dr, input int ds,
                           input logic [31:0] rd, input logic re,
                           input bit noisy);
        int sel, h, r, last, ecyc, evld;
        logic [1:0] eerr;
        logic [31:0] edata;
        logic [N-1:0] oh;
        int pulses, got_cyc, vld_cnt, bad_oh, bad_busy, bad_rdy;
        logic [31:0] got_data;
        logic [1:0] got_err;

        sel = ref_decode(a);
        oh = (sel >= 0) ? (N'(1) << sel) : '0;
        h = LIMIT + 10;
        r = LIMIT + 10;
        if (sel < 0) begin
            ecyc = 1; eerr = 2'b11; edata = '0; evld = 0;
        end else if (1 + dr > T) begin
            ecyc = T + 1; eerr = 2'b10; edata = '0; evld = T;
            h = T;
        end else begin
            h = 1 + dr;
            evld = h;
            r = h + 1 + ds;
            last = (h + 1 > T) ? h + 1 : T;
            if (r <= last) begin
                ecyc = r + 1; eerr = re ? 2'b10 : 2'b00; edata = rd;
            end else begin
                ecyc = last + 1; eerr = 2'b10; edata = '0;
            end
        end

        pulses = 0; got_cyc = -1; vld_cnt = 0;
        bad_oh = 0; bad_busy = 0; bad_rdy = 0;
        got_data = '0; got_err = '0;

        bus_if.req_valid_i   = 1'b1;
        bus_if.req_address_i = a;
        bus_if.req_write_i   = w;
        bus_if.req_data_i    = d;
        bus_if.req_strobe_i  = s;
        @(negedge clk);
        check({tag, "_ready0"}, 64'(bus_if.req_ready_o), 64'd1);
        for (int c = 1; c <= LIMIT; c++) begin
            @(posedge clk);
            #1;
            bus_if.req_valid_i = 1'b0;
            bus_if.req_data_i  = $urandom;
            slv_req_ready = N'($urandom) & ~oh;
            if (sel >= 0 && c >= 1 + dr) slv_req_ready |= oh;
            for (int k = 0; k < N; k++) begin
                slv_rsp_data[k] = $urandom;
                slv_rsp_error[k] = 1'($urandom);
            end
            slv_rsp_valid = noisy ? ~oh : (N'($urandom) & ~oh);
            if (c == r) begin
                slv_rsp_valid |= oh;
                slv_rsp_data[sel] = rd;
                slv_rsp_error[sel] = re;
            end else if (c <= h && $urandom_range(0, 1) == 1) begin
                slv_rsp_valid |= oh;
            end
            @(negedge clk);
            if (slv_req_valid != '0) begin
                vld_cnt++;
                if (slv_req_valid != oh) bad_oh++;
            end
            if (bus_if.busy_o !== (c <= ecyc)) bad_busy++;
            if (bus_if.req_ready_o !== (c > ecyc)) bad_rdy++;
            if (bus_if.rsp_valid_o) begin
                pulses++;
                got_cyc  = c;
                got_data = bus_if.rsp_data_o;
                got_err  = bus_if.rsp_error_o;
            end
            if (c == 1 && sel >= 0) begin
                check({tag, "_fields"},
                      {slv_address, slv_data},
                      {a, d});
                check({tag, "_wr_strb"},
                      64'({slv_write, slv_strobe}),
                      64'({w, s}));
            end
        end
        @(posedge clk);
        #1;
        clear_slaves();
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_cycle"}, 64'(got_cyc), 64'(ecyc));
        check({tag, "_data"}, 64'(got_data), 64'(edata));
        check({tag, "_err"}, 64'(got_err), 64'(eerr));
        check({tag, "_vld_cycles"}, 64'(vld_cnt), 64'(evld));
        check({tag, "_onehot"}, 64'(bad_oh), 64'd0);
        check({tag, "_busy"}, 64'(bad_busy), 64'd0);
        check({tag, "_ready"}, 64'(bad_rdy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, 64'(bus_if.req_ready_o), 64'd0);
        check({tag, "_rvld"}, 64'(bus_if.rsp_valid_o), 64'd0);
        check({tag, "_busy"}, 64'(bus_if.busy_o), 64'd0);
        check({tag, "_svld"}, 64'(slv_req_valid), 64'd0);
        check({tag, "_regs"},
              {bus_if.rsp_data_o, slv_address},
              64'd0);
        check({tag, "_err"},
              64'({bus_if.rsp_error_o, slv_data, slv_strobe, slv_write}),
              64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int k, sl, dr, ds, rst_pulses;

        rst = 1'b1;
        bus_if.req_valid_i   = 1'b0;
        bus_if.req_address_i = '0;
        bus_if.req_write_i   = 1'b0;
        bus_if.req_data_i    = '0;
        bus_if.req_strobe_i  = '0;
        clear_slaves();
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_txn("rd_s1", LOW_SLAVE_ADDRESS[1], 1'b0, 32'h0, 4'h0,
                0, 0, 32'hCAFE_BABE, 1'b0, 1'b0);
        run_txn("wr_unmapped", HIGH_SLAVE_ADDRESS[8] + 32'd4, 1'b1,
                32'h1234_5678, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
        run_txn("misaligned", LOW_SLAVE_ADDRESS[2] + 32'd2, 1'b0,
                32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        run_txn("timeout_s3", LOW_SLAVE_ADDRESS[3], 1'b0, 32'h0,
                4'h0, 100, 0, 32'h0, 1'b0, 1'b0);
        run_txn("distract_s4", LOW_SLAVE_ADDRESS[4] + 32'h10, 1'b0,
                32'h0, 4'h0, 1, 3, 32'h5A5A_0004, 1'b1, 1'b1);
        run_txn("overlap", 32'h4000_5900, 1'b1, 32'hA5A5_A5A5,
                4'h3, 0, 1, 32'h0000_0055, 1'b0, 1'b0);
        run_txn("rsp_on_limit", LOW_SLAVE_ADDRESS[7], 1'b0, 32'h0,
                4'h0, 0, T - 2, 32'h7777_0007, 1'b0, 1'b0);
        run_txn("rsp_past_limit", LOW_SLAVE_ADDRESS[7], 1'b0, 32'h0,
                4'h0, 0, T - 1, 32'h7777_0008, 1'b0, 1'b0);
        run_txn("hs_on_limit", LOW_SLAVE_ADDRESS[0], 1'b1, 32'hF00D,
                4'h1, T - 1, 0, 32'h0000_0099, 1'b0, 1'b0);
        run_txn("hs_on_limit_late", LOW_SLAVE_ADDRESS[0], 1'b0,
                32'h0, 4'h0, T - 1, 2, 32'h0000_0098, 1'b0, 1'b0);

        // Reset asserted while the router waits on slave 2.
        bus_if.req_valid_i   = 1'b1;
        bus_if.req_address_i = LOW_SLAVE_ADDRESS[2];
        bus_if.req_write_i   = 1'b1;
        bus_if.req_data_i    = 32'hDEAD_BEEF;
        bus_if.req_strobe_i  = 4'hF;
        @(posedge clk);
        #1;
        bus_if.req_valid_i = 1'b0;
        slv_req_ready = N'(1) << 2;
        @(posedge clk);
        #1;
        slv_req_ready = '0;
        @(negedge clk);
        check("mid_wait_busy", 64'(bus_if.busy_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        rst_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_if.rsp_valid_o) rst_pulses++;
            if (c == 1) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end
        check("mid_rst_no_pulse", 64'(rst_pulses), 64'd0);
        @(posedge clk);
        #1;
        run_txn("after_rst", LOW_SLAVE_ADDRESS[2] + 32'h20, 1'b0,
                32'h0, 4'h0, 0, 0, 32'h2222_2222, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            sl = $urandom_range(0, N - 1);
            a = LOW_SLAVE_ADDRESS[sl] + ($urandom_range(0,
                32'(HIGH_SLAVE_ADDRESS[sl] - LOW_SLAVE_ADDRESS[sl])) & ~32'd3);
            if (k == 6) a = a | 32'($urandom_range(1, 3));
            if (k == 7 || k == 8)
                a = HIGH_SLAVE_ADDRESS[N - 1] + 32'(4 * $urandom_range(1, 1000));
            if (k == 9) a = $urandom & 32'h3FFF_FFFC;
            dr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, T + 2)
                                            : $urandom_range(0, 3);
            ds = ($urandom_range(0, 5) == 0) ? $urandom_range(0, T)
                                            : $urandom_range(0, 3);
            run_txn("rand", a, 1'($urandom), $urandom, 4'($urandom),
                    dr, ds, $urandom, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_address_router.md
MMIO_ADDRESS_ROUTER -- requirements
Module: mmio_address_router

Interface
REQ-001 SHALL have parameter NETWORK_DEVICES, default soc_parameters::NETWORK_DEVICES (9), the number of slave ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the slave-silence limit in cycles; legal range 2..65535.
REQ-003 SHALL decode against soc_parameters::LOW_SLAVE_ADDRESS / HIGH_SLAVE_ADDRESS; slave i owns addresses LOW[i] <= addr <= HIGH[i], inclusive.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
  clk_i  in  1  system clock, all state on rising edge
  rst_i  in  1  asynchronous active-high reset
REQ-005 SHALL have master-side ports:
  req_valid_i  in  1  request present
  req_ready_o  out  1  request accepted this cycle
  req_address_i  in  32  byte address
  req_write_i  in  1  1=write, 0=read
  req_data_i  in  32  write data
  req_strobe_i  in  4  write byte enables
  rsp_valid_o  out  1  one-cycle response pulse
  rsp_data_o  out  32  read data
  rsp_error_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
  busy_o  out  1  transaction in flight
REQ-006 SHALL have slave-side ports:
  slv_req_valid_o  out  NETWORK_DEVICES  one-hot request valid
  slv_req_ready_i  in  NETWORK_DEVICES  per-slave accept
  slv_address_o / slv_write_o / slv_data_o / slv_strobe_o  out  32/1/32/4  broadcast request fields
  slv_rsp_valid_i  in  NETWORK_DEVICES  per-slave response valid
  slv_rsp_data_i  in  NETWORK_DEVICES x 32  per-slave read data
  slv_rsp_error_i  in  NETWORK_DEVICES  per-slave error flag

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND; one transaction outstanding at a time.
REQ-008 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-009 On acceptance, SHALL register address, write, data and strobe, and the decoded slave index; slv_* request fields SHALL hold the registered values until the next acceptance.
REQ-010 Decode SHALL be combinational on req_address_i; on overlapping ranges the lowest index SHALL win.
REQ-011 An address with no match, or with addr[1:0] != 0, SHALL go IDLE->RESPOND with rsp_error_o=11 and rsp_data_o=0; no slave valid SHALL be raised.
REQ-012 An address that matches SHALL go IDLE->ISSUE; in ISSUE, slv_req_valid_o SHALL be one-hot on the selected slave until slv_req_ready_i of that slave is 1, then go to WAIT.
REQ-013 In WAIT, slv_rsp_valid_i of the selected slave SHALL capture data and error (error -> 10, else 00), then go to RESPOND.
REQ-014 Responses from non-selected slaves, and any response outside WAIT, SHALL be ignored.
REQ-015 RESPOND SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE. Master response backpressure is not supported.
REQ-016 A 16-bit timeout counter SHALL clear on acceptance and increment each cycle in ISSUE or WAIT.
REQ-017 When the counter equals TIMEOUT_CYCLES-1 without a handshake that cycle, the FSM SHALL drop slv_req_valid_o, go to RESPOND, and return rsp_error_o=10 with rsp_data_o=0.
REQ-018 If a handshake or response coincides with the timeout cycle, the handshake SHALL win.
REQ-019 busy_o SHALL be 1 in ISSUE, WAIT and RESPOND.
REQ-020 Minimum latency SHALL be: hit with zero-wait slave, accept at cycle 0 -> rsp_valid_o at cycle 3; decode miss -> rsp_valid_o at cycle 1.

Reset
REQ-021 When rst_i is asserted, the block SHALL enter IDLE and clear the counter.
REQ-022 While rst_i is asserted, req_ready_o, rsp_valid_o, busy_o and slv_req_valid_o SHALL be 0, and all data, address and error registers SHALL be 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction silently, with no response pulse.

Verification
REQ-024 Read at LOW_SLAVE_ADDRESS[1]; slave 1 ready and response immediate, data 0xCAFEBABE -> slv_req_valid_o=0b000000010 for 1 cycle; rsp_valid_o at cycle 3, rsp_data_o=0xCAFEBABE, rsp_error_o=00.
REQ-025 Write to HIGH_SLAVE_ADDRESS[8]+4 (unmapped) -> rsp_valid_o at cycle 1, rsp_error_o=11, no slv_req_valid_o bit set.
REQ-026 Read at LOW_SLAVE_ADDRESS[2]+2 -> DECERR, rsp_data_o=0.
REQ-027 With TIMEOUT_CYCLES=16, slave 3 never ready -> slv_req_valid_o[3] high 16 cycles, then rsp_error_o=10 and rsp_data_o=0.
REQ-028 Slave 0 asserts slv_rsp_valid_i while slave 4 is selected in WAIT -> ignored; the later slave 4 response with error=1 -> rsp_error_o=10.
REQ-029 Assert rst_i in WAIT -> all outputs 0 immediately, no rsp_valid_o; next request completes normally.
